prot_secret: RTL and testbench
==============================

# prot_secret

Small protected "secret" leaf block: a registered 32-bit accumulator with a combinational bypass mux, plus a bank of width-varied pass-through lanes (1, 2, 8, 33, 64, 65, 129 bits). It is the opaque library block under protected-IP (DPI-wrapped) flows. Its job is to expose a stateful path, a combinational path and wide/odd-width ports across the protection boundary. Top-level wrappers instantiate it once per lane.

## Interface
Parameters:
- ACCUM_W, 32, accumulator and bypass datapath width. Only 32 is verified.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- accum_in  in  ACCUM_W  addend sampled every clock.
- accum_out  out  ACCUM_W  registered running sum.
- accum_bypass  in  1  selects the bypass source for accum_bypass_out.
- accum_bypass_out  out  ACCUM_W  accum_bypass ? accum_in : accum_out.
- s1_in / s1_out  in / out  1  pass-through lane.
- s2_in / s2_out  in / out  2  pass-through lane.
- s8_in / s8_out  in / out  8  pass-through lane.
- s33_in / s33_out  in / out  33  pass-through lane.
- s64_in / s64_out  in / out  64  pass-through lane.
- s65_in / s65_out  in / out  65  pass-through lane.
- s129_in / s129_out  in / out  129  pass-through lane.

## Operation
- Accumulator register acc, ACCUM_W bits. On each rising clk edge: if rst then acc <= 0, else acc <= acc + accum_in.
- accum_out = acc. This output is purely registered.
- The addition is unsigned modulo 2^ACCUM_W. Carry-out is discarded and no flag is raised.
- accum_bypass_out is a combinational mux:
  - accum_bypass=1 -> accum_in (the current, un-registered value).
  - accum_bypass=0 -> acc.
- accum_bypass only steers the output. The accumulator keeps summing regardless of accum_bypass.
- Each sN_out equals sN_in bit-for-bit, combinationally. There is no zero-extension, truncation or reordering; bit 128 of s129 and bit 64 of s65 must survive.
- The pass-through lanes are unaffected by rst.

## Timing
- accum_out latency is 1 cycle. The value after edge k is 0 plus the sum of accum_in sampled at all non-reset edges before k.
- accum_bypass_out has zero-cycle latency from accum_in, accum_bypass and acc.
- The sN lanes have zero-cycle latency.
- Reset values:
  - accum_out = 0.
  - accum_bypass_out = accum_bypass ? accum_in : 0.
  - sN_out follow their inputs.
- Reset mid-operation: the sum is discarded at the next edge and accumulation restarts from 0. accum_in presented during the reset cycle is not added.
- Toggling accum_bypass mid-run takes effect in the same cycle and does not perturb acc.
- Wrap: acc = 0xFFFF_FFFF with accum_in = 1 gives acc = 0 on the next edge.

## Structure
- Shared package prot_secret_pkg holds localparams for lane widths (S1_W=1, S2_W=2, S8_W=8, S33_W=33, S64_W=64, S65_W=65, S129_W=129) and the ACCUM_W default.
- One natural sub-module, prot_secret_accum, contains the register, adder and bypass mux.
- The top level instantiates prot_secret_accum and makes the lane assigns directly.
- No other hierarchy.

## Test plan
- Reset then accumulate: rst for 2 cycles, then accum_in = 0, 5, 10, 15 on successive edges -> accum_out = 0, 0, 5, 15, 30.
- Nonzero seed: accum_in = 100, 105, 110 -> accum_out = 100, 205, 315; with accum_bypass=0, accum_bypass_out tracks accum_out exactly.
- Bypass: after 5 cycles set accum_bypass=1 with accum_in=125 -> accum_bypass_out = 125 the same cycle; accum_out keeps summing (next edge adds 125).
- Wrap: load acc to 0xFFFF_FFFB, then accum_in=5 -> accum_out = 0x0000_0000.
- Mid-run reset: pulse rst for one cycle while accum_in=7 -> accum_out = 0 after that edge, then 7 after the next.
- Lanes: drive s129_in = {1'b1, 128'hA5A5...A5}, s65_in = {1'b1, 64'h0}, s33_in = 33'h1_0000_0001, s1/s2/s8 = all-ones then all-zeros -> each sN_out equals sN_in in the same cycle, including during rst.

Source files
------------

// File: rtl/prot_secret_pkg.sv
// prot_secret shared package: accumulator width default and
// pass-through lane widths used by the top and the testbench.
package prot_secret_pkg;

  localparam int ACCUM_W_DEF = 32;

  localparam int S1_W   = 1;
  localparam int S2_W   = 2;
  localparam int S8_W   = 8;
  localparam int S33_W  = 33;
  localparam int S64_W  = 64;
  localparam int S65_W  = 65;
  localparam int S129_W = 129;

endpackage

// File: rtl/prot_secret_accum.sv
// Registered running-sum accumulator with a combinational bypass mux.
// Ports: clk, rst (sync, active-high), accum_in, accum_bypass,
//        accum_out (registered sum), accum_bypass_out (mux output).
module prot_secret_accum
  import prot_secret_pkg::*;
#(
  parameter int ACCUM_W = ACCUM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACCUM_W-1:0] accum_in,
  input  logic               accum_bypass,
  output logic [ACCUM_W-1:0] accum_out,
  output logic [ACCUM_W-1:0] accum_bypass_out
);

  logic [ACCUM_W-1:0] acc_q;
  logic [ACCUM_W-1:0] acc_d;

  // Sum wraps modulo 2^ACCUM_W; carry-out is dropped on purpose.
  always_comb begin
    acc_d = acc_q + accum_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign accum_out = acc_q;

  // Bypass only steers the output; acc_q keeps summing either way.
  assign accum_bypass_out = accum_bypass ? accum_in : acc_q;

endmodule

// File: rtl/prot_secret.sv
// prot_secret: opaque leaf exposing a stateful accumulator path, a
// combinational bypass path and odd/wide pass-through lanes.
// Ports: clk, rst, accum_in/out, accum_bypass, accum_bypass_out,
//        sN_in/sN_out for N in {1,2,8,33,64,65,129}.
module prot_secret
  import prot_secret_pkg::*;
#(
  parameter int ACCUM_W = ACCUM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACCUM_W-1:0] accum_in,
  output logic [ACCUM_W-1:0] accum_out,
  input  logic               accum_bypass,
  output logic [ACCUM_W-1:0] accum_bypass_out,
  input  logic [S1_W-1:0]    s1_in,
  output logic [S1_W-1:0]    s1_out,
  input  logic [S2_W-1:0]    s2_in,
  output logic [S2_W-1:0]    s2_out,
  input  logic [S8_W-1:0]    s8_in,
  output logic [S8_W-1:0]    s8_out,
  input  logic [S33_W-1:0]   s33_in,
  output logic [S33_W-1:0]   s33_out,
  input  logic [S64_W-1:0]   s64_in,
  output logic [S64_W-1:0]   s64_out,
  input  logic [S65_W-1:0]   s65_in,
  output logic [S65_W-1:0]   s65_out,
  input  logic [S129_W-1:0]  s129_in,
  output logic [S129_W-1:0]  s129_out
);

  prot_secret_accum #(
    .ACCUM_W (ACCUM_W)
  ) u_accum (
    .clk              (clk),
    .rst              (rst),
    .accum_in         (accum_in),
    .accum_bypass     (accum_bypass),
    .accum_out        (accum_out),
    .accum_bypass_out (accum_bypass_out)
  );

  // Lanes are pure wires across the boundary and ignore rst.
  assign s1_out   = s1_in;
  assign s2_out   = s2_in;
  assign s8_out   = s8_in;
  assign s33_out  = s33_in;
  assign s64_out  = s64_in;
  assign s65_out  = s65_in;
  assign s129_out = s129_in;

endmodule

// File: tb/tb_prot_secret.sv
// Directed table-driven bench for prot_secret: accumulator, bypass,
// wrap, mid-run reset, and bit-exact pass-through lanes.
module tb_prot_secret;

  logic         clk;
  logic         rst;
  logic [31:0]  accum_in;
  logic [31:0]  accum_out;
  logic         accum_bypass;
  logic [31:0]  accum_bypass_out;
  logic         s1_in, s1_out;
  logic [1:0]   s2_in, s2_out;
  logic [7:0]   s8_in, s8_out;
  logic [32:0]  s33_in, s33_out;
  logic [63:0]  s64_in, s64_out;
  logic [64:0]  s65_in, s65_out;
  logic [128:0] s129_in, s129_out;

  int total;
  int passed;

  prot_secret dut (
    .clk              (clk),
    .rst              (rst),
    .accum_in         (accum_in),
    .accum_out        (accum_out),
    .accum_bypass     (accum_bypass),
    .accum_bypass_out (accum_bypass_out),
    .s1_in            (s1_in),
    .s1_out           (s1_out),
    .s2_in            (s2_in),
    .s2_out           (s2_out),
    .s8_in            (s8_in),
    .s8_out           (s8_out),
    .s33_in           (s33_in),
    .s33_out          (s33_out),
    .s64_in           (s64_in),
    .s64_out          (s64_out),
    .s65_in           (s65_in),
    .s65_out          (s65_out),
    .s129_in          (s129_in),
    .s129_out         (s129_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        byp;
    logic [31:0] din;
    logic        chk_comb;
    logic [31:0] exp_comb;
    logic [31:0] exp_acc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [128:0] act,
                       input logic [128:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic b,
                              input logic [31:0] d, input logic cc,
                              input logic [31:0] ec,
                              input logic [31:0] ea);
    vec_t v;
    v.rst = r;
    v.byp = b;
    v.din = d;
    v.chk_comb = cc;
    v.exp_comb = ec;
    v.exp_acc = ea;
    return v;
  endfunction

  task automatic check_lanes(input string tag);
    #1;
    check({tag, "_s1"},   129'(s1_out),   129'(s1_in));
    check({tag, "_s2"},   129'(s2_out),   129'(s2_in));
    check({tag, "_s8"},   129'(s8_out),   129'(s8_in));
    check({tag, "_s33"},  129'(s33_out),  129'(s33_in));
    check({tag, "_s64"},  129'(s64_out),  129'(s64_in));
    check({tag, "_s65"},  129'(s65_out),  129'(s65_in));
    check({tag, "_s129"}, s129_out,       s129_in);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    accum_in = '0;
    accum_bypass = 1'b0;
    s1_in = '0;
    s2_in = '0;
    s8_in = '0;
    s33_in = '0;
    s64_in = '0;
    s65_in = '0;
    s129_in = '0;

    // rst byp din chk exp_comb exp_acc(after edge)
    // Reset then accumulate 0,5,10,15.
    vecs.push_back(mk(1, 0, 32'd9,   0, 32'd0,   32'd0));
    vecs.push_back(mk(1, 1, 32'd3,   1, 32'd3,   32'd0));
    vecs.push_back(mk(0, 0, 32'd0,   1, 32'd0,   32'd0));
    vecs.push_back(mk(0, 0, 32'd5,   1, 32'd0,   32'd5));
    vecs.push_back(mk(0, 0, 32'd10,  1, 32'd5,   32'd15));
    vecs.push_back(mk(0, 0, 32'd15,  1, 32'd15,  32'd30));
    // Bypass on: output shows accum_in, sum still advances.
    vecs.push_back(mk(0, 1, 32'd125, 1, 32'd125, 32'd155));
    vecs.push_back(mk(0, 0, 32'd100, 1, 32'd155, 32'd255));
    // Mid-run reset with accum_in=7: not added.
    vecs.push_back(mk(1, 1, 32'd7,   1, 32'd7,   32'd0));
    vecs.push_back(mk(0, 0, 32'd7,   1, 32'd0,   32'd7));
    // Nonzero seed after reset.
    vecs.push_back(mk(1, 0, 32'd50,  1, 32'd7,   32'd0));
    vecs.push_back(mk(0, 0, 32'd100, 1, 32'd0,   32'd100));
    vecs.push_back(mk(0, 0, 32'd105, 1, 32'd100, 32'd205));
    vecs.push_back(mk(0, 0, 32'd110, 1, 32'd205, 32'd315));
    // Wrap: load 0xFFFF_FFFB, add 5.
    vecs.push_back(mk(1, 0, 32'd0,   1, 32'd315, 32'd0));
    vecs.push_back(mk(0, 0, 32'hFFFF_FFFB, 1, 32'd0, 32'hFFFF_FFFB));
    vecs.push_back(mk(0, 0, 32'd5,   1, 32'hFFFF_FFFB, 32'd0));
    vecs.push_back(mk(0, 0, 32'hFFFF_FFFF, 1, 32'd0, 32'hFFFF_FFFF));
    vecs.push_back(mk(0, 0, 32'd1,   1, 32'hFFFF_FFFF, 32'd0));
    vecs.push_back(mk(0, 1, 32'd42,  1, 32'd42,  32'd42));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      accum_bypass = vecs[i].byp;
      accum_in = vecs[i].din;
      #1;
      if (vecs[i].chk_comb)
        check($sformatf("v%0d_bypass_out", i),
              129'(accum_bypass_out), 129'(vecs[i].exp_comb));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_accum_out", i),
            129'(accum_out), 129'(vecs[i].exp_acc));
    end

    // Bypass toggles within a cycle without disturbing acc (acc=42).
    @(negedge clk);
    rst = 1'b0;
    accum_in = 32'd8;
    accum_bypass = 1'b1;
    #1;
    check("tog_byp1", 129'(accum_bypass_out), 129'(32'd8));
    accum_bypass = 1'b0;
    #1;
    check("tog_byp0", 129'(accum_bypass_out), 129'(32'd42));
    @(posedge clk);
    #1;
    check("tog_acc", 129'(accum_out), 129'(32'd50));

    // Lanes under reset and not, with all-ones and all-zeros patterns.
    @(negedge clk);
    rst = 1'b1;
    accum_in = '0;
    s129_in = {1'b1, {16{8'hA5}}};
    s65_in = {1'b1, 64'h0};
    s64_in = 64'h8000_0000_0000_0001;
    s33_in = 33'h1_0000_0001;
    s1_in = 1'b1;
    s2_in = 2'b11;
    s8_in = 8'hFF;
    check_lanes("rst_ones");
    @(posedge clk);
    check_lanes("rst_ones_post");
    check("lane_rst_acc", 129'(accum_out), 129'(32'd0));
    @(negedge clk);
    rst = 1'b0;
    s1_in = 1'b0;
    s2_in = 2'b00;
    s8_in = 8'h00;
    s33_in = 33'h0_8000_0000;
    s64_in = 64'h0;
    s65_in = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    s129_in = {1'b0, {16{8'h5A}}};
    check_lanes("run_zeros");
    @(negedge clk);
    s129_in = {1'b1, 128'h0};
    s65_in = {1'b1, 64'h1};
    check_lanes("run_msb");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
